// File: rtl/svc_rv_div_ctrl_pkg.sv
// Shared constants for the RV32M divide/remainder sequencer.
// The op encoding equals funct3[1:0] of the divide-class instructions.
package svc_rv_div_ctrl_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [1:0] DIV_OP_REM  = 2'd2;
  localparam logic [1:0] DIV_OP_REMU = 2'd3;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/svc_rv_div_ctrl.sv
// Radix-2 restoring divide/remainder sequencer for the EX stage.
// Holds the instruction in EX through op_active and drops it in the DONE cycle.
module svc_rv_div_ctrl
  import svc_rv_div_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            op_active,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e state_q, state_d;
  logic is_rem_q, is_rem_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] div_q, div_d, rem_q, rem_d, quo_q, quo_d, result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  // One restoring step; the trial subtraction needs XLEN+1 bits because the
  // shifted partial remainder can exceed XLEN bits before it is reduced.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                 input logic [XLEN-1:0] quo,
                                                 input logic [XLEN-1:0] dvs);
    logic [XLEN:0] part;
    logic [XLEN:0] trial;
    part  = {rem, quo[XLEN-1]};
    trial = part - {1'b0, dvs};
    if (!trial[XLEN]) return {trial[XLEN-1:0], quo[XLEN-2:0], 1'b1};
    return {part[XLEN-1:0], quo[XLEN-2:0], 1'b0};
  endfunction

  logic            sgn_op, rs1_neg, rs2_neg, div_zero, sgn_ovf, accept, keep;
  logic [2*XLEN-1:0] step;
  logic [XLEN-1:0] rem_nx, quo_nx;

  assign sgn_op   = op_is_signed(op);
  assign rs1_neg  = sgn_op & rs1[XLEN-1];
  assign rs2_neg  = sgn_op & rs2[XLEN-1];
  assign div_zero = (rs2 == '0);
  assign sgn_ovf  = sgn_op && (rs1 == XMIN) && (rs2 == '1);
  assign accept   = start && !flush;
  assign keep     = start && !flush;
  assign step     = div_step(rem_q, quo_q, div_q);
  assign rem_nx   = step[2*XLEN-1:XLEN];
  assign quo_nx   = step[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div_q     <= div_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (div_zero || sgn_ovf) ? DONE : CALC;
      CALC: begin
        if (!keep) state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div_d     = div_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    unique case (state_q)
      IDLE: if (accept) begin
        is_rem_d  = op_is_rem(op);
        neg_quo_d = rs1_neg ^ rs2_neg;
        neg_rem_d = rs1_neg;
        div_d     = rs2_neg ? negate(rs2) : rs2;
        quo_d     = rs1_neg ? negate(rs1) : rs1;
        rem_d     = '0;
        cnt_d     = '0;
        if (div_zero)     result_d = op_is_rem(op) ? rs1 : '1;
        else if (sgn_ovf) result_d = op_is_rem(op) ? '0 : XMIN;
      end
      CALC: if (keep) begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CNT_W'(1);
        // Sign fix-up is folded into the final iteration so result is registered.
        if (cnt_q == CNT_LAST) begin
          if (is_rem_q) result_d = neg_rem_q ? negate(rem_nx) : rem_nx;
          else          result_d = neg_quo_q ? negate(quo_nx) : quo_nx;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    op_active    = start && (state_q != DONE) && !rst;
    result_valid = (state_q == DONE) && !rst;
    result       = rst ? '0 : result_q;
  end

endmodule

// File: tb/tb_svc_rv_div_ctrl.sv
// Scoreboard bench for svc_rv_div_ctrl: directed RV32M cases, aborts,
// back-to-back issue and a randomized mix including mid-operation reset.
module tb_svc_rv_div_ctrl;
  import svc_rv_div_ctrl_pkg::*;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;
  localparam logic [XLEN-1:0] XMIN = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rst, start, flush;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1, rs2;
  logic            op_active, result_valid;
  logic [XLEN-1:0] result;

  svc_rv_div_ctrl #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .rs1          (rs1),
    .rs2          (rs2),
    .flush        (flush),
    .op_active    (op_active),
    .result_valid (result_valid),
    .result       (result)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [XLEN-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int last_done_cyc = 0;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got,
                          input logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_special(input logic [1:0] o, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    return (b == '0) ||
           ((o == DIV_OP_DIV || o == DIV_OP_REM) && a == XMIN && b == '1);
  endfunction

  function automatic logic [XLEN-1:0] model(input logic [1:0] o, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    int sa;
    int sb;
    bit ovf;
    sa  = a;
    sb  = b;
    ovf = (a == XMIN) && (b == '1);
    case (o)
      DIV_OP_DIVU: return (b == '0) ? '1 : a / b;
      DIV_OP_REMU: return (b == '0) ? a : a % b;
      DIV_OP_DIV: begin
        if (b == '0) return '1;
        if (ovf) return XMIN;
        return XLEN'(sa / sb);
      end
      default: begin
        if (b == '0) return a;
        if (ovf) return '0;
        return XLEN'(sa % sb);
      end
    endcase
  endfunction

  // scoreboard: every result_valid pops one expected value
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      last_done_cyc = cyc;
      if (exp_q.size() == 0) check_eq("spurious_valid", XLEN'(result_valid), '0);
      else check_eq("result", result, exp_q.pop_front());
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE; checks latency and that op_active is high on every
  // cycle before DONE and low in DONE. Returns at posedge+1 after DONE.
  task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input bit hold);
    int lat;
    int exp_lat;
    bit act_ok;
    op = o; rs1 = a; rs2 = b; start = 1'b1; flush = 1'b0;
    exp_q.push_back(model(o, a, b));
    exp_lat = is_special(o, a, b) ? 1 : LAT;
    lat = -1;
    act_ok = 1'b1;
    for (int c = 0; c <= LAT + 4 && lat < 0; c++) begin
      @(negedge clk);
      if (result_valid === 1'b1) lat = c;
      if (op_active !== (c != exp_lat)) act_ok = 1'b0;
    end
    check_eq("latency", XLEN'(lat), XLEN'(exp_lat));
    check_eq("op_active_seq", XLEN'(act_ok), XLEN'(1));
    if (lat < 0) exp_q.delete();
    next_cycle();
    if (!hold) start = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return XMIN;
      2:       return '1;
      3:       return XLEN'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // Start a regular op and kill it at CALC cycle k, by flush or by dropping start.
  task automatic abort_op(input int k, input bit use_flush);
    op = 2'($urandom_range(0, 3)); rs1 = $urandom(); rs2 = XLEN'($urandom_range(1, 1000));
    start = 1'b1; flush = 1'b0;
    for (int c = 0; c < k; c++) next_cycle();
    if (use_flush) flush = 1'b1;
    else start = 1'b0;
    next_cycle();
    flush = 1'b0;
  endtask

  // Start a regular op, assert reset at CALC cycle k and check the reset outputs.
  task automatic rst_mid(input int k);
    op = 2'($urandom_range(0, 3)); rs1 = $urandom(); rs2 = XLEN'($urandom_range(1, 1000));
    start = 1'b1; flush = 1'b0;
    for (int c = 0; c < k; c++) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_op_active", XLEN'(op_active), '0);
    check_eq("rst_valid", XLEN'(result_valid), '0);
    check_eq("rst_result", result, '0);
    next_cycle();
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_eq("post_rst_valid", XLEN'(result_valid), '0);
    check_eq("post_rst_result", result, '0);
    next_cycle();
  endtask

  initial begin
    int d1;
    rst = 1'b1; start = 1'b1; flush = 1'b0; op = DIV_OP_DIVU; rs1 = 32'd100; rs2 = 32'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_op_active", XLEN'(op_active), '0);
    check_eq("reset_valid", XLEN'(result_valid), '0);
    check_eq("reset_result", result, '0);
    next_cycle();
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_eq("after_reset_valid", XLEN'(result_valid), '0);
    check_eq("after_reset_result", result, '0);
    next_cycle();

    // unsigned and signed basics
    run_op(DIV_OP_DIVU, 32'd100, 32'd7, 1'b0);
    run_op(DIV_OP_REMU, 32'd100, 32'd7, 1'b0);
    run_op(DIV_OP_DIV, -32'sd7, 32'd2, 1'b0);
    run_op(DIV_OP_REM, -32'sd7, 32'd2, 1'b0);
    run_op(DIV_OP_DIV, 32'd7, -32'sd2, 1'b0);
    run_op(DIV_OP_REM, 32'd7, -32'sd2, 1'b0);
    // divide by zero and signed overflow
    run_op(DIV_OP_DIVU, 32'd5, 32'd0, 1'b0);
    run_op(DIV_OP_REMU, 32'd5, 32'd0, 1'b0);
    run_op(DIV_OP_DIV, -32'sd5, 32'd0, 1'b0);
    run_op(DIV_OP_DIV, XMIN, 32'hFFFF_FFFF, 1'b0);
    run_op(DIV_OP_REM, XMIN, 32'hFFFF_FFFF, 1'b0);
    // result must hold between DONE pulses
    repeat (3) next_cycle();
    check_eq("result_hold", result, '0);

    // flush at CALC cycle 10, then a new op right after
    abort_op(10, 1'b1);
    run_op(DIV_OP_DIVU, 32'd9, 32'd3, 1'b0);
    abort_op(XLEN, 1'b0);
    run_op(DIV_OP_REMU, 32'd1000, 32'd7, 1'b0);

    // back-to-back with start held high
    run_op(DIV_OP_DIVU, 32'd100, 32'd7, 1'b1);
    d1 = last_done_cyc;
    run_op(DIV_OP_DIVU, 32'd200, 32'd9, 1'b0);
    check_eq("b2b_gap", XLEN'(last_done_cyc - d1), XLEN'(LAT + 1));

    // randomized mix
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 39))
        0:       rst_mid($urandom_range(1, XLEN));
        1:       abort_op($urandom_range(1, XLEN), 1'b1);
        2:       abort_op($urandom_range(1, XLEN), 1'b0);
        default: ;
      endcase
      run_op(2'($urandom_range(0, 3)), rand_val(), rand_val(), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    repeat (4) next_cycle();
    check_eq("queue_drained", XLEN'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
